// File: rtl/input_debounce_ctrl.sv
// ---------------------------------------------------------------------------
// input_debounce_ctrl
//
// Multi-channel conditioner for asynchronous board inputs (keys, switches,
// external strobes). Each channel is brought into the clk domain through a
// two-flop synchronizer. A debounce state machine then accepts a new level
// only after the level has held for DEBOUNCE_TICKS consecutive sample ticks
// of a shared, free-running timebase. Accepted edges produce one-cycle
// rise/fall pulses and set sticky event flags. The flags are cleared by
// writing 1 to clr_mask, and their OR drives a single interrupt line.
//
// Parameters:
//   WIDTH          number of input channels
//   TICK_DIV       clk cycles per sample tick (>= 2)
//   DEBOUNCE_TICKS ticks a new level must hold before acceptance (>= 1)
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   async_in     raw asynchronous inputs, one bit per channel
//   clr_valid    one-cycle strobe that qualifies clr_mask
//   clr_mask     write-1-to-clear mask for event_flags
//   stable_out   debounced levels
//   rise_pulse   one-cycle pulse on an accepted 0->1 change
//   fall_pulse   one-cycle pulse on an accepted 1->0 change
//   event_flags  sticky record of rise/fall events per channel
//   irq          OR of all event_flags
// ---------------------------------------------------------------------------
module input_debounce_ctrl #(
    parameter int WIDTH          = 4,
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    input  logic             clr_valid,
    input  logic [WIDTH-1:0] clr_mask,
    output logic [WIDTH-1:0] stable_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] event_flags,
    output logic             irq
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_TICKS - 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } deb_state_e;

    // -----------------------------------------------------------------------
    // Two-flop synchronizer. Only sync2_q is used downstream.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
        end
    end

    // -----------------------------------------------------------------------
    // Shared sample-tick timebase. Free-running; input activity never
    // restarts it, so the first tick after a change can land anywhere
    // within one TICK_DIV period. That is where the latency window comes from.
    // -----------------------------------------------------------------------
    logic [TW-1:0] tick_cnt_q;
    logic [TW-1:0] tick_cnt_d;
    logic          tick;

    assign tick = (tick_cnt_q == TICK_LAST);

    always_comb begin
        tick_cnt_d = tick_cnt_q + TW'(1);
        if (tick) begin
            tick_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel debounce FSM, edge pulses and sticky flag.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
        deb_state_e    state_q;
        deb_state_e    state_d;
        logic [CW-1:0] count_q;
        logic [CW-1:0] count_d;
        logic          stable_q;
        logic          stable_d;
        logic          rise_q;
        logic          rise_d;
        logic          fall_q;
        logic          fall_d;
        logic          flag_q;
        logic          flag_d;
        logic          accept;
        logic          clr_hit;

        always_comb begin
            state_d  = state_q;
            count_d  = count_q;
            stable_d = stable_q;
            accept   = 1'b0;

            case (state_q)
                ST_STABLE: begin
                    // A tick in the entry cycle is not counted: the level
                    // must survive DEBOUNCE_TICKS full ticks after entry.
                    if (sync2_q[gi] != stable_q) begin
                        state_d = ST_PENDING;
                        count_d = '0;
                    end
                end
                ST_PENDING: begin
                    if (sync2_q[gi] == stable_q) begin
                        // Bounced back before acceptance: drop the attempt.
                        state_d = ST_STABLE;
                        count_d = '0;
                    end else if (tick) begin
                        if (count_q == CNT_LAST) begin
                            accept   = 1'b1;
                            stable_d = sync2_q[gi];
                            count_d  = '0;
                            state_d  = ST_STABLE;
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_STABLE;
                    count_d = '0;
                end
            endcase

            // Pulses are registered alongside stable_q so they coincide
            // with the visible level change.
            rise_d = accept & sync2_q[gi];
            fall_d = accept & ~sync2_q[gi];

            // The flag is set from the registered pulse, so a clear in the
            // pulse cycle loses to the set.
            clr_hit = clr_valid & clr_mask[gi];
            flag_d  = (flag_q & ~clr_hit) | rise_q | fall_q;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q  <= ST_STABLE;
                count_q  <= '0;
                stable_q <= 1'b0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
                flag_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                count_q  <= count_d;
                stable_q <= stable_d;
                rise_q   <= rise_d;
                fall_q   <= fall_d;
                flag_q   <= flag_d;
            end
        end

        assign stable_out[gi]  = stable_q;
        assign rise_pulse[gi]  = rise_q;
        assign fall_pulse[gi]  = fall_q;
        assign event_flags[gi] = flag_q;
    end

    assign irq = |event_flags;

endmodule

// File: tb/tb_input_debounce_ctrl.sv
module tb_input_debounce_ctrl;

    localparam int W  = 4;
    localparam int TD = 4;
    localparam int DT = 3;

    logic         clk;
    logic         reset;
    logic [W-1:0] async_in;
    logic         clr_valid;
    logic [W-1:0] clr_mask;
    logic [W-1:0] stable_out;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
    logic [W-1:0] event_flags;
    logic         irq;

    input_debounce_ctrl #(
        .WIDTH         (W),
        .TICK_DIV      (TD),
        .DEBOUNCE_TICKS(DT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .async_in   (async_in),
        .clr_valid  (clr_valid),
        .clr_mask   (clr_mask),
        .stable_out (stable_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .event_flags(event_flags),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Pulse counters per channel, written only by the compare process.
    int rise_cnt [W];
    int fall_cnt [W];

    // -----------------------------------------------------------------------
    // Behavioural model.
    // Each channel remembers the edge index at which its synchronized level
    // began to disagree with the accepted level. Tick edges are the edges n
    // (counted from reset release, first edge = 1) with n % TD == 0, so the
    // number of ticks seen since entry is now/TD - since/TD. A level is
    // accepted once that reaches DT while the disagreement persists.
    // -----------------------------------------------------------------------
    logic [W-1:0] m_s1, m_s2, m_stable, m_rise, m_fall, m_flags;
    logic [W-1:0] m_nr, m_nf;
    int           m_since [W];
    int           m_ecount;

    initial begin
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0; m_fall = '0;
        m_flags = '0; m_ecount = 0;
        for (int i = 0; i < W; i++) m_since[i] = -1;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0;
                m_fall = '0; m_flags = '0; m_ecount = 0;
                for (int i = 0; i < W; i++) m_since[i] = -1;
            end else begin
                m_ecount = m_ecount + 1;
                m_flags  = (m_flags & ~(clr_valid ? clr_mask : '0)) | m_rise | m_fall;
                m_nr = '0;
                m_nf = '0;
                for (int i = 0; i < W; i++) begin
                    if (m_s2[i] != m_stable[i]) begin
                        if (m_since[i] < 0) begin
                            m_since[i] = m_ecount;
                        end else if ((m_ecount / TD) - (m_since[i] / TD) >= DT) begin
                            m_stable[i] = m_s2[i];
                            m_nr[i]     = m_s2[i];
                            m_nf[i]     = ~m_s2[i];
                            m_since[i]  = -1;
                        end
                    end else begin
                        m_since[i] = -1;
                    end
                end
                m_rise = m_nr;
                m_fall = m_nf;
                m_s2   = m_s1;
                m_s1   = async_in;
            end
        end
    end

    // Compare process: every falling edge outside reset.
    initial begin
        for (int i = 0; i < W; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int i = 0; i < W; i++) begin
                    rise_cnt[i] = rise_cnt[i] + int'(rise_pulse[i]);
                    fall_cnt[i] = fall_cnt[i] + int'(fall_pulse[i]);
                end
                n_cmp = n_cmp + 1;
                if (stable_out !== m_stable || rise_pulse !== m_rise ||
                    fall_pulse !== m_fall || event_flags !== m_flags ||
                    irq !== (|m_flags)) begin
                    n_fail = n_fail + 1;
                    $display("FAIL model_cycle t=%0t got stable=%b rise=%b fall=%b flags=%b irq=%b required stable=%b rise=%b fall=%b flags=%b irq=%b",
                             $time, stable_out, rise_pulse, fall_pulse, event_flags, irq,
                             m_stable, m_rise, m_fall, m_flags, |m_flags);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got no finish required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        n_cmp = n_cmp + 1;
        if (got < lo || got > hi) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got %0d required %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Latency counted from the first clk edge that samples the new level.
    task automatic wait_stable(input int ch, input logic val, output int lat);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (stable_out[ch] == val) begin
                lat = k;
                break;
            end
        end
    endtask

    int lat;
    int snap;
    int found;
    int hold [W];

    initial begin
        async_in  = '0;
        clr_valid = 1'b0;
        clr_mask  = '0;
        reset     = 1'b1;
        step(3);
        check("reset_state", {stable_out, rise_pulse, fall_pulse, event_flags, irq}, 32'h0);
        reset = 1'b0;
        step(5);
        $display("tx reset_release");

        // Clean rise on channel 0.
        async_in[0] = 1'b1;
        wait_stable(0, 1'b1, lat);
        check_range("clean_rise_latency", lat, 11, 14);
        check("clean_rise_pulse", 32'(rise_pulse[0]), 32'h1);
        step(1);
        check("clean_rise_pulse_width", 32'(rise_pulse[0]), 32'h0);
        check("clean_rise_flags", 32'(event_flags), 32'h1);
        check("clean_rise_irq", 32'(irq), 32'h1);
        check("clean_rise_others", 32'(stable_out[3:1]), 32'h0);
        $display("tx clean_rise latency=%0d", lat);

        // Bounce rejection on channel 1.
        snap = rise_cnt[1] + fall_cnt[1];
        for (int k = 0; k < 20; k++) begin
            async_in[1] = ~async_in[1];
            step(3);
        end
        async_in[1] = 1'b0;
        step(20);
        check("bounce_stable", 32'(stable_out[1]), 32'h0);
        check("bounce_pulses", 32'(rise_cnt[1] + fall_cnt[1] - snap), 32'h0);
        check("bounce_flag", 32'(event_flags[1]), 32'h0);
        $display("tx bounce_reject");

        // Bounce then settle high on channel 2.
        snap = rise_cnt[2];
        for (int k = 0; k < 4; k++) begin
            async_in[2] = ~async_in[2];
            step(2);
        end
        async_in[2] = 1'b1;
        wait_stable(2, 1'b1, lat);
        check_range("settle_latency", lat, 11, 14);
        step(20);
        check("settle_one_rise", 32'(rise_cnt[2] - snap), 32'h1);
        $display("tx bounce_settle latency=%0d", lat);

        // Clear semantics.
        clr_valid = 1'b1;
        clr_mask  = 4'hF;
        step(1);
        clr_valid = 1'b0;
        clr_mask  = 4'h0;
        check("clear_all", 32'(event_flags), 32'h0);
        async_in[0] = 1'b0;
        async_in[1] = 1'b1;
        wait_stable(1, 1'b1, lat);
        step(2);
        check("flags_0011", 32'(event_flags), 32'h3);
        clr_valid = 1'b1;
        clr_mask  = 4'b0001;
        step(1);
        clr_valid = 1'b0;
        check("clear_bit0_flags", 32'(event_flags), 32'h2);
        check("clear_bit0_irq", 32'(irq), 32'h1);
        clr_mask = 4'hF;
        step(2);
        check("mask_ignored", 32'(event_flags), 32'h2);
        clr_mask = 4'h0;
        $display("tx clear_mask");

        // Clear coincident with a fall pulse on channel 1: set wins.
        async_in[1] = 1'b0;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (fall_pulse[1]) begin
                found = 1;
                break;
            end
        end
        check("fall1_seen", 32'(found), 32'h1);
        clr_valid = 1'b1;
        clr_mask  = 4'b0010;
        step(1);
        clr_valid = 1'b0;
        clr_mask  = 4'h0;
        check("set_beats_clear", 32'(event_flags[1]), 32'h1);
        $display("tx clear_vs_set");

        // Simultaneous rise on channels 0 and 3.
        async_in[0] = 1'b1;
        async_in[3] = 1'b1;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (rise_pulse[0]) begin
                found = 1;
                break;
            end
        end
        check("simul_rise0", 32'(found), 32'h1);
        check("simul_rise3", 32'(rise_pulse[3]), 32'h1);
        step(2);
        $display("tx simultaneous");

        // Reset in the middle of a pending debounce.
        async_in = '0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(3);
        async_in[0] = 1'b1;
        found = 0;
        for (int k = 0; k < 30; k++) begin
            step(1);
            if (m_since[0] >= 0 && (m_ecount / TD) - (m_since[0] / TD) == 2) begin
                found = 1;
                break;
            end
        end
        check("pending_two_ticks", 32'(found), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", {stable_out, rise_pulse, fall_pulse, event_flags, irq}, 32'h0);
        step(3);
        snap = rise_cnt[0];
        reset = 1'b0;
        wait_stable(0, 1'b1, lat);
        check_range("post_reset_latency", lat, 11, 14);
        step(5);
        check("post_reset_one_rise", 32'(rise_cnt[0] - snap), 32'h1);
        $display("tx reset_mid_pending latency=%0d", lat);

        // Randomized traffic: mixes short bounces and long holds.
        for (int i = 0; i < W; i++) hold[i] = $urandom_range(1, 20);
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < W; i++) begin
                hold[i] = hold[i] - 1;
                if (hold[i] <= 0) begin
                    async_in[i] = ~async_in[i];
                    hold[i] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 5)
                                                          : $urandom_range(12, 30);
                end
            end
            clr_valid = ($urandom_range(0, 7) == 0);
            clr_mask  = W'($urandom);
            step(1);
        end
        clr_valid = 1'b0;
        step(5);
        $display("tx random_traffic rises=%0d %0d %0d %0d", rise_cnt[0], rise_cnt[1], rise_cnt[2], rise_cnt[3]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
